// File: rtl/lector_sensor_temp_pkg.sv
// Shared definitions for the cabin temperature reader and the child-presence alarm FSM.
package lector_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CS_SETUP = 3'd1,
    SHIFT    = 3'd2,
    CS_HOLD  = 3'd3,
    UPDATE   = 3'd4,
    WAIT     = 3'd5
  } lector_state_e;

  localparam logic [4:0] TEMP_MAX    = 5'd31;
  // Hot threshold used by the alarm FSM on the consumer side of temp_o.
  localparam logic [4:0] TEMP_UMBRAL = 5'd20;

endpackage

// File: rtl/lector_sensor_temp_if.sv
// Sensor pin bundle (SPI mode 0, read-only); master is the reader, slave is the sensor.
interface lector_sensor_temp_if;
  logic sclk_o;
  logic cs_n_o;
  logic sdo_i;

  modport master (output sclk_o, output cs_n_o, input sdo_i);
  modport slave  (input sclk_o, input cs_n_o, output sdo_i);
endinterface

// File: rtl/lector_sensor_temp_divisor_tick.sv
// Free-running clk_i divider producing a one-cycle tick every CLK_DIV cycles.
module divisor_tick #(
  parameter int CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == CNT_MAX);

endmodule

// File: rtl/lector_sensor_temp.sv
// Periodic SPI reader for the cabin temperature sensor; saturates the signed
// 8-bit reading to 0..31 degC for the alarm FSM.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | after reset; starts the first conversion on the next cycle
// CS_SETUP | cs_n low, sclk low, one tick before the first clock edge
// SHIFT    | 16 ticks: 8 rising edges sample sdo, 8 falling edges count
// CS_HOLD  | sclk low, cs_n still low for one tick
// UPDATE   | saturate the word, register temp/sat, pulse temp_valid
// WAIT     | cs_n high until the sample period expires
module lector_sensor_temp
  import lector_pkg::*;
#(
  parameter int CLK_DIV       = 2,
  parameter int SAMPLE_PERIOD = 64,
  parameter int DATA_BITS     = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  lector_sensor_temp_if.master spi,
  output logic [4:0]           temp_o,
  output logic                 temp_valid_o,
  output logic                 sat_o,
  output logic                 busy_o
);

  if (CLK_DIV < 2) begin : g_chk_div
    $error("lector_sensor_temp: CLK_DIV must be >= 2");
  end
  if (SAMPLE_PERIOD < 18 * CLK_DIV + 2) begin : g_chk_period
    $error("lector_sensor_temp: SAMPLE_PERIOD too short for one conversion");
  end
  if (DATA_BITS != 8) begin : g_chk_bits
    $error("lector_sensor_temp: sensor word is fixed at 8 bits");
  end

  localparam int PW = $clog2(SAMPLE_PERIOD);
  localparam logic [PW-1:0] PER_LAST = PW'(SAMPLE_PERIOD - 1);

  lector_state_e state, state_nxt;

  logic [DATA_BITS-1:0] shift_q;
  logic [2:0]           bit_cnt;
  logic [PW-1:0]        per_cnt;
  logic                 sclk_q, sclk_nxt;
  logic                 cs_n_q;
  logic                 tick;
  logic                 enter_setup;
  logic                 shift_ld, bit_inc, bit_clr, upd;
  logic [5:0]           sat_temp;

  // Returns {sat, temp}; raw is two's complement, so bit 7 alone flags negative.
  function automatic logic [5:0] saturar(input logic [DATA_BITS-1:0] raw);
    if (raw[DATA_BITS-1]) begin
      return {1'b1, 5'd0};
    end else if (|raw[DATA_BITS-2:5]) begin
      return {1'b1, TEMP_MAX};
    end else begin
      return {1'b0, raw[4:0]};
    end
  endfunction

  assign enter_setup = (state_nxt == CS_SETUP) && (state != CS_SETUP);
  assign sat_temp    = saturar(shift_q);

  divisor_tick #(.CLK_DIV(CLK_DIV)) u_div (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr   (enter_setup),
    .tick  (tick)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sclk_nxt  = 1'b0;
    shift_ld  = 1'b0;
    bit_inc   = 1'b0;
    bit_clr   = 1'b0;
    upd       = 1'b0;
    case (state)
      IDLE: state_nxt = CS_SETUP;
      CS_SETUP: begin
        if (tick) begin
          state_nxt = SHIFT;
          bit_clr   = 1'b1;
        end
      end
      SHIFT: begin
        sclk_nxt = sclk_q;
        if (tick) begin
          sclk_nxt = ~sclk_q;
          if (!sclk_q) begin
            shift_ld = 1'b1;
          end else begin
            bit_inc = 1'b1;
            if (bit_cnt == 3'd7) begin
              state_nxt = CS_HOLD;
            end
          end
        end
      end
      CS_HOLD: begin
        if (tick) begin
          state_nxt = UPDATE;
        end
      end
      UPDATE: begin
        upd       = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (per_cnt == PER_LAST) begin
          state_nxt = CS_SETUP;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pin and status outputs are registered from next state so they line up
  // with the state register and never glitch.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sclk_q <= 1'b0;
      cs_n_q <= 1'b1;
      busy_o <= 1'b0;
    end else begin
      sclk_q <= sclk_nxt;
      cs_n_q <= !(state_nxt inside {CS_SETUP, SHIFT, CS_HOLD});
      busy_o <= state_nxt inside {CS_SETUP, SHIFT, CS_HOLD, UPDATE};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shift_q <= '0;
      bit_cnt <= '0;
      per_cnt <= '0;
    end else begin
      if (shift_ld) begin
        shift_q <= {shift_q[DATA_BITS-2:0], spi.sdo_i};
      end
      if (bit_clr) begin
        bit_cnt <= '0;
      end else if (bit_inc) begin
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (enter_setup) begin
        per_cnt <= '0;
      end else begin
        per_cnt <= per_cnt + PW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      temp_o       <= '0;
      sat_o        <= 1'b0;
      temp_valid_o <= 1'b0;
    end else begin
      temp_valid_o <= upd;
      if (upd) begin
        sat_o  <= sat_temp[5];
        temp_o <= sat_temp[4:0];
      end
    end
  end

  assign spi.sclk_o = sclk_q;
  assign spi.cs_n_o = cs_n_q;

endmodule

// File: tb/tb_lector_sensor_temp.sv
// Bench for lector_sensor_temp: two instances (default and CLK_DIV=5) driven by
// a behavioural SPI sensor model, checked against an arithmetic saturation model.
module tb_lector_sensor_temp;
  import lector_pkg::*;

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic [4:0] temp_a, temp_b;
  logic       valid_a, valid_b, sat_a, sat_b, busy_a, busy_b;
  logic [7:0] next_word_a, next_word_b;
  logic [7:0] word_a, word_b;
  int         cyc = 0;
  int         n_chk = 0;
  int         n_pass = 0;
  int         last_valid_a = 0;

  int r_got, r_lat, r_rises, r_hmin, r_hmax, r_setup, r_hold, r_tchg, r_tv;

  lector_sensor_temp_if spi_a();
  lector_sensor_temp_if spi_b();

  lector_sensor_temp #(.CLK_DIV(2), .SAMPLE_PERIOD(64), .DATA_BITS(8)) dut_a (
    .clk_i(clk), .rst_i(rst_a), .spi(spi_a),
    .temp_o(temp_a), .temp_valid_o(valid_a), .sat_o(sat_a), .busy_o(busy_a)
  );

  lector_sensor_temp #(.CLK_DIV(5), .SAMPLE_PERIOD(100), .DATA_BITS(8)) dut_b (
    .clk_i(clk), .rst_i(rst_b), .spi(spi_b),
    .temp_o(temp_b), .temp_valid_o(valid_b), .sat_o(sat_b), .busy_o(busy_b)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Sensor model: MSB valid once cs_n falls, next bit after every sclk fall,
  // random noise while deselected.
  initial begin : sensor_a
    logic pc, ps;
    int   nf;
    pc = 1'b1; ps = 1'b0; nf = 0; word_a = '0;
    spi_a.sdo_i = 1'b0;
    forever begin
      @(negedge clk);
      if (spi_a.cs_n_o !== 1'b0) begin
        nf = 0;
        spi_a.sdo_i = 1'($urandom_range(0, 1));
      end else begin
        if (pc) word_a = next_word_a;
        else if (ps && !spi_a.sclk_o) nf++;
        spi_a.sdo_i = (nf < 8) ? word_a[7-nf] : 1'b0;
      end
      pc = spi_a.cs_n_o;
      ps = spi_a.sclk_o;
    end
  end

  initial begin : sensor_b
    logic pc, ps;
    int   nf;
    pc = 1'b1; ps = 1'b0; nf = 0; word_b = '0;
    spi_b.sdo_i = 1'b0;
    forever begin
      @(negedge clk);
      if (spi_b.cs_n_o !== 1'b0) begin
        nf = 0;
        spi_b.sdo_i = 1'($urandom_range(0, 1));
      end else begin
        if (pc) word_b = next_word_b;
        else if (ps && !spi_b.sclk_o) nf++;
        spi_b.sdo_i = (nf < 8) ? word_b[7-nf] : 1'b0;
      end
      pc = spi_b.cs_n_o;
      ps = spi_b.sclk_o;
    end
  end

  function automatic int exp_temp(input logic [7:0] w);
    int v;
    v = int'($signed(w));
    if (v < 0) return 0;
    if (v > 31) return 31;
    return v;
  endfunction

  function automatic int exp_sat(input logic [7:0] w);
    int v;
    v = int'($signed(w));
    return (v < 0 || v > 31) ? 1 : 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Observe one conversion on instance sel until its temp_valid pulse.
  task automatic conv(input bit sel, input int budget);
    logic s, c, v, ps, pc;
    logic [4:0] t, pt;
    int t_cs, t_edge, t_fall;
    r_got = 0; r_lat = -1; r_rises = 0; r_hmin = 1000000; r_hmax = -1;
    r_setup = -1; r_hold = -1; r_tchg = 0; r_tv = -1;
    t_cs = -1; t_edge = -1; t_fall = -1;
    ps = sel ? spi_b.sclk_o : spi_a.sclk_o;
    pc = sel ? spi_b.cs_n_o : spi_a.cs_n_o;
    pt = sel ? temp_b : temp_a;
    for (int i = 0; i < budget && r_got == 0; i++) begin
      @(negedge clk);
      s = sel ? spi_b.sclk_o : spi_a.sclk_o;
      c = sel ? spi_b.cs_n_o : spi_a.cs_n_o;
      v = sel ? valid_b : valid_a;
      t = sel ? temp_b : temp_a;
      if (pc && !c) t_cs = cyc;
      if (!c && s !== ps) begin
        if (t_edge >= 0) begin
          if (cyc - t_edge < r_hmin) r_hmin = cyc - t_edge;
          if (cyc - t_edge > r_hmax) r_hmax = cyc - t_edge;
        end
        t_edge = cyc;
        if (s) begin
          r_rises++;
          if (r_setup < 0 && t_cs >= 0) r_setup = cyc - t_cs;
        end else begin
          t_fall = cyc;
        end
      end
      if (!pc && c && t_fall >= 0) r_hold = cyc - t_fall;
      if (v === 1'b1) begin
        r_got = 1;
        r_tv  = cyc;
        if (t_cs >= 0) r_lat = cyc - t_cs;
      end else if (t !== pt) begin
        r_tchg++;
      end
      ps = s; pc = c; pt = t;
    end
  endtask

  task automatic run_a(input string tag, input logic [7:0] w, input bit chk_per);
    next_word_a = w;
    conv(1'b0, 200);
    check({tag, "_lat"}, r_lat, 37);
    check({tag, "_temp"}, temp_a, exp_temp(w));
    check({tag, "_sat"}, sat_a, exp_sat(w));
    check({tag, "_rises"}, r_rises, 8);
    check({tag, "_stable"}, r_tchg, 0);
    check({tag, "_busy"}, busy_a, 0);
    if (chk_per) check({tag, "_period"}, r_tv - last_valid_a, 64);
    last_valid_a = r_tv;
    @(negedge clk);
    check({tag, "_vwidth"}, valid_a, 0);
  endtask

  initial begin : main
    logic [7:0] dir_words [6];
    logic       ps;
    int         rises;
    logic [7:0] wb;

    dir_words = '{8'h20, 8'h7F, 8'h80, 8'hFF, 8'h01, 8'h1E};
    rst_a = 1'b1; rst_b = 1'b1;
    next_word_a = 8'h00; next_word_b = 8'h17;
    repeat (3) @(negedge clk);
    check("rst_sclk", spi_a.sclk_o, 0);
    check("rst_cs_n", spi_a.cs_n_o, 1);
    check("rst_temp", temp_a, 0);
    check("rst_valid", valid_a, 0);
    check("rst_sat", sat_a, 0);
    check("rst_busy", busy_a, 0);

    rst_a = 1'b0;
    run_a("t1", 8'h14, 1'b0);
    check("t1_half_min", r_hmin, 2);
    check("t1_half_max", r_hmax, 2);
    check("t1_setup", r_setup, 4);
    check("t1_hold", r_hold, 2);

    run_a("t2_hot", 8'h2D, 1'b1);
    run_a("t2_max", 8'h1F, 1'b1);
    run_a("t3_neg", 8'hF6, 1'b1);
    run_a("t3_zero", 8'h00, 1'b1);
    for (int i = 0; i < 6; i++) run_a("dir", dir_words[i], 1'b1);
    for (int i = 0; i < 8; i++) run_a("rnd", 8'($urandom), 1'b1);
    run_a("pre_rst", 8'h11, 1'b1);

    // Reset in the middle of a transfer.
    next_word_a = 8'($urandom);
    rises = 0;
    ps = spi_a.sclk_o;
    for (int i = 0; i < 200 && rises < 4; i++) begin
      @(negedge clk);
      if (!spi_a.cs_n_o && spi_a.sclk_o && !ps) rises++;
      ps = spi_a.sclk_o;
    end
    check("mr_reach4", rises, 4);
    check("mr_busy_before", busy_a, 1);
    rst_a = 1'b1;
    @(negedge clk);
    check("mr_cs_n", spi_a.cs_n_o, 1);
    check("mr_sclk", spi_a.sclk_o, 0);
    check("mr_temp", temp_a, 0);
    check("mr_valid", valid_a, 0);
    check("mr_busy", busy_a, 0);
    rst_a = 1'b0;
    run_a("mr_fresh", 8'h19, 1'b0);

    // Slow instance: CLK_DIV=5, SAMPLE_PERIOD=100.
    rst_b = 1'b0;
    conv(1'b1, 300);
    check("b_lat", r_lat, 91);
    check("b_rises", r_rises, 8);
    check("b_half_min", r_hmin, 5);
    check("b_half_max", r_hmax, 5);
    check("b_setup", r_setup, 10);
    check("b_hold", r_hold, 5);
    check("b_temp", temp_b, exp_temp(8'h17));
    check("b_sat", sat_b, exp_sat(8'h17));
    last_valid_a = r_tv;
    wb = 8'($urandom);
    next_word_b = wb;
    conv(1'b1, 300);
    check("b2_lat", r_lat, 91);
    check("b2_period", r_tv - last_valid_a, 100);
    check("b2_temp", temp_b, exp_temp(wb));
    check("b2_sat", sat_b, exp_sat(wb));
    check("b2_stable", r_tchg, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
